// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared constants, loader state type and helper function for
//               the instruction-memory program loader.
//               Optional feature macro: IMEM_LOADER_CHECKSUM_EN
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  localparam int IMEM_DEPTH = 256;
  localparam int IMEM_AW    = 8;

  // CHECK exists only when the trailing checksum word is part of the stream.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHECK  = 3'd3,
`endif
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } load_state_t;

  // Header length field is one bit wider than the address so it can hold DEPTH.
  function automatic int hdr_len_width(input int aw);
    return aw + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_load_ctrl
// Description : Loader FSM, length latch, write address and word counter.
//               Optional feature macro: IMEM_LOADER_CHECKSUM_EN
// Revision    : 1.0 - initial release
// ============================================================================
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW,
  parameter int LW    = hdr_len_width(IMEM_AW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  input  logic [LW-1:0] hdr_len,
`ifdef IMEM_LOADER_CHECKSUM_EN
  input  logic          chk_ok,
  output logic          start_acc,
`endif
  output logic          s_ready,
  output logic          cpu_stall,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded,
  output logic [AW-1:0] addr,
  output logic          data_beat
);

  localparam logic [LW-1:0] DEPTH_W = LW'(DEPTH);

  load_state_t   state;
  logic [LW-1:0] len;
  logic          beat;

  // A beat transfers whenever the source is valid and the loader is ready.
  assign beat      = s_valid & s_ready;
  assign data_beat = beat && (state == ST_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
`endif

  // Loader FSM with registered handshake, stall and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      len          <= '0;
      addr         <= '0;
      words_loaded <= '0;
      s_ready      <= 1'b0;
      cpu_stall    <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_HEADER;
            addr         <= '0;
            words_loaded <= '0;
            s_ready      <= 1'b1;
            cpu_stall    <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
          end
        end
        ST_HEADER: begin
          if (beat) begin
            if ((hdr_len == '0) || (hdr_len > DEPTH_W)) begin
              state     <= ST_ERR;
              s_ready   <= 1'b0;
              cpu_stall <= 1'b0;
              error     <= 1'b1;
            end else begin
              len   <= hdr_len;
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (beat) begin
            words_loaded <= words_loaded + LW'(1);
            if ((words_loaded + LW'(1)) == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state     <= ST_CHECK;
`else
              state     <= ST_DONE;
              s_ready   <= 1'b0;
              cpu_stall <= 1'b0;
              done      <= 1'b1;
`endif
            end else begin
              // Only advance while words remain so a full image never wraps.
              addr <= addr + AW'(1);
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (beat) begin
            s_ready   <= 1'b0;
            cpu_stall <= 1'b0;
            if (chk_ok) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          s_ready   <= 1'b0;
          cpu_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Streams a length-prefixed program image into the instruction
//               memory through a registered write port, stalling the CPU
//               until the image is complete.
//               Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing
//               XOR checksum word verified before DONE).
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [31:0]   s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_stall,
  output logic          done,
  output logic          error,
  output logic [AW:0]   words_loaded
);

  localparam int LW = hdr_len_width(AW);

  logic [AW-1:0] addr;
  logic          data_beat;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] chk_acc;
  logic        chk_ok;
  logic        start_acc;

  // Received checksum must equal the XOR of every data word in the image.
  assign chk_ok = (chk_acc == s_data);

  // Running XOR over data beats, restarted by each honoured start.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_acc <= '0;
    end else if (start_acc) begin
      chk_acc <= '0;
    end else if (data_beat) begin
      chk_acc <= chk_acc ^ s_data;
    end
  end
`endif

  imem_load_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .LW    (LW)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .s_valid      (s_valid),
    .hdr_len      (s_data[LW-1:0]),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .chk_ok       (chk_ok),
    .start_acc    (start_acc),
`endif
    .s_ready      (s_ready),
    .cpu_stall    (cpu_stall),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .addr         (addr),
    .data_beat    (data_beat)
  );

  // Registered write port: one-cycle strobe the cycle after each data beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= data_beat;
      if (data_beat) begin
        mem_waddr <= addr;
        mem_wdata <= s_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        cpu_stall;
  logic        done;
  logic        error;
  logic [8:0]  words_loaded;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0]  oa[$];
  logic [31:0] od[$];
  int          oc[$];

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .cpu_stall    (cpu_stall),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every memory write with the cycle it occurred in.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      oa.push_back(mem_waddr);
      od.push_back(mem_wdata);
      oc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] d);
    int  t;
    bit  ok;
    t = 0;
    ok = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (!ok && t < 50) begin
      if (s_ready === 1'b1) ok = 1;
      @(negedge clk);
      t++;
    end
    s_valid = 1'b0;
    chk("accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"},   32'(s_ready),      32'd0);
    chk({tag, "_mem_we"},    32'(mem_we),       32'd0);
    chk({tag, "_waddr"},     32'(mem_waddr),    32'd0);
    chk({tag, "_wdata"},     mem_wdata,         32'd0);
    chk({tag, "_stall"},     32'(cpu_stall),    32'd0);
    chk({tag, "_done"},      32'(done),         32'd0);
    chk({tag, "_error"},     32'(error),        32'd0);
    chk({tag, "_words"},     32'(words_loaded), 32'd0);
  endtask

  // One complete load checked against a model built from the loader rules.
  task automatic do_load(input int n, input bit toggle, input bit bad_ck, input bit start_mid);
    logic [31:0] words[$];
    logic [31:0] ck;
    logic [31:0] d;
    bit          hdr_bad;
    bit          exp_err;
    ck = '0;
    hdr_bad = (n == 0) || (n > 256);
    oa.delete(); od.delete(); oc.delete();

    pulse_start();
    chk("start_stall", 32'(cpu_stall), 32'd1);
    chk("start_ready", 32'(s_ready),   32'd1);
    chk("start_done",  32'(done),      32'd0);
    chk("start_error", 32'(error),     32'd0);
    chk("start_words", 32'(words_loaded), 32'd0);

    // Upper header bits are random garbage the loader must ignore.
    send(($urandom() << 9) | (32'(n) & 32'h1FF));

    if (hdr_bad) begin
      chk("badhdr_error", 32'(error),     32'd1);
      chk("badhdr_done",  32'(done),      32'd0);
      chk("badhdr_ready", 32'(s_ready),   32'd0);
      chk("badhdr_stall", 32'(cpu_stall), 32'd0);
      @(negedge clk); @(negedge clk);
      chk("badhdr_nowrites", 32'(oa.size()), 32'd0);
      chk("badhdr_words", 32'(words_loaded), 32'd0);
      return;
    end

    for (int i = 0; i < n; i++) begin
      d = $urandom();
      words.push_back(d);
      ck = ck ^ d;
      if (toggle && i > 0) @(negedge clk);
      if (start_mid && i == 1) start = 1'b1;
      send(d);
      start = 1'b0;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(bad_ck ? ~ck : ck);
    exp_err = bad_ck;
`else
    exp_err = 1'b0;
`endif
    @(negedge clk); @(negedge clk);

    chk("load_done",  32'(done),         32'(!exp_err));
    chk("load_error", 32'(error),        32'(exp_err));
    chk("load_words", 32'(words_loaded), 32'(n));
    chk("load_stall", 32'(cpu_stall),    32'd0);
    chk("load_ready", 32'(s_ready),      32'd0);
    chk("load_nwrites", 32'(oa.size()),  32'(n));
    if (oa.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk("wr_addr", 32'(oa[i]), 32'(i));
        chk("wr_data", od[i], words[i]);
        if (!toggle) chk("wr_consecutive", 32'(oc[i] - oc[0]), 32'(i));
        if (toggle && i > 0) chk("wr_spacing", 32'(oc[i] - oc[i-1]), 32'd2);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    do_load(4, 1'b0, 1'b0, 1'b0);
    do_load(0, 1'b0, 1'b0, 1'b0);
    do_load(257, 1'b0, 1'b0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    do_load(4, 1'b0, 1'b1, 1'b0);
`endif
    do_load(256, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a 4-word load, after the second data beat.
    pulse_start();
    send(32'd4);
    send($urandom());
    send($urandom());
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    do_load(1, 1'b0, 1'b0, 1'b0);

    do_load(6, 1'b0, 1'b0, 1'b1);
    do_load(int'($urandom_range(1, 40)), 1'b0, 1'b0, 1'b0);
    do_load(int'($urandom_range(1, 40)), 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
